// File: rtl/rem_pkg.sv
// Shared types and constants for the rem arbiter slice.
package rem_pkg;

  localparam int REM_W     = 3;
  localparam int SIGN_BIT  = 2;
  localparam int DBZ_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    RESP = 2'b10
  } state_t;

endpackage

// File: rtl/rem_arbiter_if.sv
// Request/response bundle between requesters, consumer and the rem arbiter.
interface rem_arbiter_if
  import rem_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]       req_valid;
  logic [REM_W*NUM_REQ-1:0] req_num;
  logic [REM_W*NUM_REQ-1:0] req_den;
  logic [NUM_REQ-1:0]       req_ready;

  logic                     rsp_valid;
  logic [ID_W-1:0]          rsp_id;
  logic [REM_W-1:0]         rsp_rem;
  logic                     rsp_divbyzero;
  logic                     rsp_ready;

  modport master (
    output req_valid, req_num, req_den, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_rem, rsp_divbyzero
  );

  modport slave (
    input  req_valid, req_num, req_den, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_rem, rsp_divbyzero
  );

endinterface

// File: rtl/rem.sv
// 3-bit sign-magnitude remainder with divide-by-zero flag (combinational).
module rem
  import rem_pkg::*;
(
  input  logic [REM_W-1:0] numerator,
  input  logic [REM_W-1:0] denominator,
  output logic [REM_W-1:0] remainder,
  output logic             divbyzero
);

  // Magnitude modulo, sign follows the numerator; zero divisor flagged.
  always_comb begin
    divbyzero = (denominator[SIGN_BIT-1:0] == '0);
    remainder = {numerator[SIGN_BIT], {(REM_W-1){1'b0}}};
    if (!divbyzero) begin
      remainder[SIGN_BIT-1:0] = numerator[SIGN_BIT-1:0] % denominator[SIGN_BIT-1:0];
    end
  end

endmodule

// File: rtl/rem_arbiter.sv
// Round-robin arbiter sharing one rem unit among NUM_REQ requesters.
module rem_arbiter
  import rem_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  rem_arbiter_if.slave         bus,
  output logic                 busy,
  output logic [DBZ_CNT_W-1:0] dbz_count
);

  state_t             state;
  logic [ID_W-1:0]    ptr;
  logic [REM_W-1:0]   num_q;
  logic [REM_W-1:0]   den_q;
  logic [ID_W-1:0]    id_q;

  logic [ID_W-1:0]    rsp_id_q;
  logic [REM_W-1:0]   rsp_rem_q;
  logic               rsp_dbz_q;

  logic               gnt_found;
  logic [ID_W-1:0]    gnt_idx;
  logic [ID_W-1:0]    cand;

  logic [REM_W-1:0]   rem_out;
  logic               rem_dbz;

  rem u_rem (
    .numerator   (num_q),
    .denominator (den_q),
    .remainder   (rem_out),
    .divbyzero   (rem_dbz)
  );

  // Round-robin pick: first valid requester at or above ptr, wrapping.
  // NUM_REQ is a power of two, so ID_W-bit addition wraps modulo NUM_REQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = ptr + ID_W'(k);
      if (!gnt_found && bus.req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // One-hot grant, only offered while idle.
  always_comb begin
    bus.req_ready = '0;
    if (state == IDLE && gnt_found) begin
      bus.req_ready = NUM_REQ'(1) << gnt_idx;
    end
  end

  assign busy              = (state != IDLE);
  assign bus.rsp_valid     = (state == RESP);
  assign bus.rsp_id        = rsp_id_q;
  assign bus.rsp_rem       = rsp_rem_q;
  assign bus.rsp_divbyzero = rsp_dbz_q;

  // Sequencer: grant and latch operands, compute, then hold the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      num_q <= '0;
      den_q <= '0;
      id_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_found) begin
            num_q <= bus.req_num[REM_W*gnt_idx +: REM_W];
            den_q <= bus.req_den[REM_W*gnt_idx +: REM_W];
            id_q  <= gnt_idx;
            ptr   <= gnt_idx + ID_W'(1);
            state <= CALC;
          end
        end
        CALC: state <= RESP;
        RESP: begin
          if (bus.rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Response registers captured from the rem unit at the end of CALC.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_id_q  <= '0;
      rsp_rem_q <= '0;
      rsp_dbz_q <= 1'b0;
    end else if (state == CALC) begin
      rsp_id_q  <= id_q;
      rsp_dbz_q <= rem_dbz;
      rsp_rem_q <= rem_dbz ? {num_q[SIGN_BIT], {(REM_W-1){1'b0}}} : rem_out;
    end
  end

  // Saturating divide-by-zero event counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      dbz_count <= '0;
    end else if (state == CALC && rem_dbz && dbz_count != '1) begin
      dbz_count <= dbz_count + DBZ_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rem_arbiter.sv
// Self-checking bench for rem_arbiter with a behavioural reference model.
module tb_rem_arbiter;
  import rem_pkg::*;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy;
  logic [7:0] dbz_count;
  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;

  rem_arbiter_if #(.NUM_REQ(N), .ID_W(2)) bus ();

  rem_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .dbz_count (dbz_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not complete, got running want finished");
    $fatal(1, "timeout");
  end

  function automatic logic [2:0] ref_rem(input int n, input int d);
    int mag;
    if (d % 4 == 0) mag = 0;
    else mag = (n % 4) % (d % 4);
    return 3'((n / 4) * 4 + mag);
  endfunction

  function automatic bit ref_dbz(input int d);
    return (d % 4) == 0;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs one request through requester id; reports what the DUT returned.
  task automatic do_op(input int id, input logic [2:0] n, input logic [2:0] d,
                       output bit ok, output int lat, output logic [1:0] oid,
                       output logic [2:0] orem, output logic odbz, output logic [7:0] ocnt);
    int gc;
    bit g;
    ok = 0; lat = -1; oid = '0; orem = '0; odbz = 1'b0; ocnt = '0; g = 0; gc = 0;
    @(negedge clk);
    bus.req_valid = '0;
    bus.req_valid[id] = 1'b1;
    bus.req_num[3*id +: 3] = n;
    bus.req_den[3*id +: 3] = d;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (bus.req_ready[id]) begin g = 1; gc = cyc; break; end
      @(negedge clk);
    end
    @(negedge clk);
    bus.req_valid[id] = 1'b0;
    if (g) begin
      for (int k = 0; k < 20; k++) begin
        #1;
        if (bus.rsp_valid) begin
          ok = 1; lat = cyc - gc; oid = bus.rsp_id; orem = bus.rsp_rem;
          odbz = bus.rsp_divbyzero; ocnt = dbz_count;
          break;
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    bus.req_valid = '0;
    bus.req_num = '0;
    bus.req_den = '0;
    bus.rsp_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.req_ready !== 4'b0000) begin miscompares++; $display("FAIL reset_req_ready got %b want 0000", bus.req_ready); end
    vectors++;
    if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
    vectors++;
    if (bus.rsp_id !== 2'd0 || bus.rsp_rem !== 3'd0 || bus.rsp_divbyzero !== 1'b0) begin
      miscompares++; $display("FAIL reset_rsp_fields got id=%0d rem=%b dbz=%b want 0/000/0", bus.rsp_id, bus.rsp_rem, bus.rsp_divbyzero);
    end
    vectors++;
    if (busy !== 1'b0 || dbz_count !== 8'd0) begin
      miscompares++; $display("FAIL reset_busy_cnt got busy=%b cnt=%0d want 0/0", busy, dbz_count);
    end
    vectors++;
    if (dut.ptr !== 2'd0) begin miscompares++; $display("FAIL reset_ptr got %0d want 0", dut.ptr); end
  endtask

  task automatic test_single();
    @(negedge clk);
    bus.req_valid = 4'b0100;
    bus.req_num[8:6] = 3'b011;
    bus.req_den[8:6] = 3'b010;
    bus.rsp_ready = 1'b1;
    #1;
    vectors++;
    if (bus.req_ready !== 4'b0100) begin miscompares++; $display("FAIL single_grant got %b want 0100", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    vectors++;
    if (bus.rsp_valid !== 1'b0 || busy !== 1'b1) begin
      miscompares++; $display("FAIL single_calc got valid=%b busy=%b want 0/1", bus.rsp_valid, busy);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd2 || bus.rsp_rem !== 3'b001 || bus.rsp_divbyzero !== 1'b0) begin
      miscompares++; $display("FAIL single_rsp got v=%b id=%0d rem=%b dbz=%b want 1/2/001/0",
                              bus.rsp_valid, bus.rsp_id, bus.rsp_rem, bus.rsp_divbyzero);
    end
    vectors++;
    if (dut.ptr !== 2'd3) begin miscompares++; $display("FAIL single_ptr got %0d want 3", dut.ptr); end
    @(negedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      miscompares++; $display("FAIL single_done got busy=%b valid=%b want 0/0", busy, bus.rsp_valid);
    end
  endtask

  task automatic test_divbyzero();
    bit ok; int lat; logic [1:0] oid; logic [2:0] orem; logic odbz; logic [7:0] ocnt;
    int mcnt;
    mcnt = int'(dbz_count);
    do_op(0, 3'b111, 3'b100, ok, lat, oid, orem, odbz, ocnt);
    mcnt++;
    vectors++;
    if (!ok || orem !== 3'b100 || odbz !== 1'b1) begin
      miscompares++; $display("FAIL dbz_a got ok=%0d rem=%b dbz=%b want 1/100/1", ok, orem, odbz);
    end
    do_op(0, 3'b010, 3'b000, ok, lat, oid, orem, odbz, ocnt);
    mcnt++;
    vectors++;
    if (!ok || orem !== 3'b000 || odbz !== 1'b1) begin
      miscompares++; $display("FAIL dbz_b got ok=%0d rem=%b dbz=%b want 1/000/1", ok, orem, odbz);
    end
    vectors++;
    if (ocnt !== 8'(mcnt)) begin miscompares++; $display("FAIL dbz_count got %0d want %0d", ocnt, mcnt); end
    while (mcnt < 255) begin
      do_op($urandom_range(0, 3), 3'($urandom), {$urandom_range(0, 1) == 1, 2'b00}, ok, lat, oid, orem, odbz, ocnt);
      mcnt++;
    end
    vectors++;
    if (ocnt !== 8'd255) begin miscompares++; $display("FAIL dbz_reach_255 got %0d want 255", ocnt); end
    do_op(1, 3'b001, 3'b100, ok, lat, oid, orem, odbz, ocnt);
    vectors++;
    if (!ok || ocnt !== 8'd255) begin miscompares++; $display("FAIL dbz_saturate got ok=%0d cnt=%0d want 1/255", ok, ocnt); end
  endtask

  task automatic test_contention();
    int gidx[$]; int gcyc[$]; int rid[$]; int rcyc[$];
    do_reset();
    bus.req_valid = 4'b1111;
    for (int i = 0; i < N; i++) begin
      bus.req_num[3*i +: 3] = 3'($urandom);
      bus.req_den[3*i +: 3] = 3'($urandom);
    end
    for (int c = 0; c < 16; c++) begin
      #1;
      if (bus.req_ready !== 4'b0000) begin
        vectors++;
        if ($countones(bus.req_ready) != 1) begin
          miscompares++; $display("FAIL cont_onehot got %b want one-hot", bus.req_ready);
        end
        for (int i = 0; i < N; i++) if (bus.req_ready[i]) begin gidx.push_back(i); gcyc.push_back(cyc); end
      end
      if (bus.rsp_valid === 1'b1) begin rid.push_back(int'(bus.rsp_id)); rcyc.push_back(cyc); end
      @(negedge clk);
    end
    bus.req_valid = '0;
    vectors++;
    if (gidx.size() < 5 || rid.size() < 4) begin
      miscompares++; $display("FAIL cont_count got grants=%0d rsps=%0d want >=5/>=4", gidx.size(), rid.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        vectors++;
        if (gidx[k] != k % N) begin miscompares++; $display("FAIL cont_order[%0d] got %0d want %0d", k, gidx[k], k % N); end
        if (k > 0) begin
          vectors++;
          if (gcyc[k] - gcyc[k-1] != 3) begin
            miscompares++; $display("FAIL cont_spacing[%0d] got %0d want 3", k, gcyc[k] - gcyc[k-1]);
          end
        end
        if (k < 4) begin
          vectors++;
          if (rid[k] != gidx[k] || rcyc[k] != gcyc[k] + 2) begin
            miscompares++; $display("FAIL cont_rsp[%0d] got id=%0d lat=%0d want id=%0d lat=2", k, rid[k], rcyc[k] - gcyc[k], gidx[k]);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [2:0] erem; logic edbz;
    do_reset();
    @(negedge clk);
    bus.req_valid = 4'b0001;
    bus.req_num[2:0] = 3'b110;
    bus.req_den[2:0] = 3'b011;
    bus.rsp_ready = 1'b0;
    erem = ref_rem(6, 3);
    edbz = ref_dbz(3);
    #1;
    vectors++;
    if (bus.req_ready !== 4'b0001) begin miscompares++; $display("FAIL bp_grant got %b want 0001", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 4'b0010;
    bus.req_num[5:3] = 3'b011;
    bus.req_den[5:3] = 3'b001;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      #1;
      vectors++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_rem !== erem ||
          bus.rsp_divbyzero !== edbz || bus.req_ready !== 4'b0000) begin
        miscompares++; $display("FAIL bp_hold[%0d] got v=%b id=%0d rem=%b dbz=%b rdy=%b want 1/0/%b/%b/0000",
                                c, bus.rsp_valid, bus.rsp_id, bus.rsp_rem, bus.rsp_divbyzero, bus.req_ready, erem, edbz);
      end
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    #1;
    vectors++;
    if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 4'b0000) begin
      miscompares++; $display("FAIL bp_handshake got v=%b rdy=%b want 1/0000", bus.rsp_valid, bus.req_ready);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (bus.req_ready !== 4'b0010 || bus.rsp_valid !== 1'b0) begin
      miscompares++; $display("FAIL bp_next_grant got rdy=%b v=%b want 0010/0", bus.req_ready, bus.rsp_valid);
    end
    @(negedge clk);
    bus.req_valid = '0;
  endtask

  task automatic test_reset_calc();
    int seen;
    do_reset();
    @(negedge clk);
    bus.req_valid = 4'b1000;
    bus.req_num[11:9] = 3'b101;
    bus.req_den[11:9] = 3'b000;
    #1;
    vectors++;
    if (bus.req_ready !== 4'b1000) begin miscompares++; $display("FAIL rstc_grant got %b want 1000", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = '0;
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL rstc_in_calc got busy=%b want 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.rsp_valid !== 1'b0 || busy !== 1'b0 || dut.ptr !== 2'd0 || dbz_count !== 8'd0) begin
      miscompares++; $display("FAIL rstc_state got v=%b busy=%b ptr=%0d cnt=%0d want 0/0/0/0",
                              bus.rsp_valid, busy, dut.ptr, dbz_count);
    end
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      if (bus.rsp_valid !== 1'b0) seen++;
    end
    vectors++;
    if (seen != 0) begin miscompares++; $display("FAIL rstc_no_rsp got %0d response cycles want 0", seen); end
  endtask

  task automatic test_sweep();
    bit ok; int lat; logic [1:0] oid; logic [2:0] orem; logic odbz; logic [7:0] ocnt;
    for (int n = 0; n < 8; n++) begin
      for (int d = 0; d < 8; d++) begin
        do_op(0, 3'(n), 3'(d), ok, lat, oid, orem, odbz, ocnt);
        vectors++;
        if (!ok || lat != 2 || oid !== 2'd0 || orem !== ref_rem(n, d) || odbz !== logic'(ref_dbz(d))) begin
          miscompares++; $display("FAIL sweep n=%0d d=%0d got ok=%0d lat=%0d id=%0d rem=%b dbz=%b want 1/2/0/%b/%b",
                                  n, d, ok, lat, oid, orem, odbz, ref_rem(n, d), ref_dbz(d));
        end
      end
    end
  endtask

  task automatic test_random();
    bit [3:0] pend;
    int pn[4]; int pd[4];
    int mptr, gcyc, eid, en, ed, mcnt, j;
    bit outst, expv;
    logic [3:0] erdy;
    do_reset();
    pend = '0; mptr = 0; outst = 0; gcyc = 0; eid = 0; en = 0; ed = 0; mcnt = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1; pn[i] = $urandom_range(0, 7); pd[i] = $urandom_range(0, 7);
        end
        bus.req_num[3*i +: 3] = 3'(pn[i]);
        bus.req_den[3*i +: 3] = 3'(pd[i]);
      end
      bus.req_valid = pend;
      bus.rsp_ready = ($urandom_range(0, 2) != 0);
      #1;
      expv = outst && (cyc >= gcyc + 2);
      vectors++;
      if (bus.rsp_valid !== expv || busy !== outst) begin
        miscompares++; $display("FAIL rand_valid cyc=%0d got v=%b busy=%b want %b/%b", cyc, bus.rsp_valid, busy, expv, outst);
      end
      if (expv) begin
        vectors++;
        if (bus.rsp_id !== 2'(eid) || bus.rsp_rem !== ref_rem(en, ed) || bus.rsp_divbyzero !== logic'(ref_dbz(ed)) ||
            dbz_count !== 8'(mcnt)) begin
          miscompares++; $display("FAIL rand_rsp cyc=%0d got id=%0d rem=%b dbz=%b cnt=%0d want %0d/%b/%b/%0d",
                                  cyc, bus.rsp_id, bus.rsp_rem, bus.rsp_divbyzero, dbz_count,
                                  eid, ref_rem(en, ed), ref_dbz(ed), mcnt);
        end
      end
      erdy = '0;
      j = -1;
      if (!outst) begin
        for (int k = 0; k < N; k++) begin
          if (j < 0 && pend[(mptr + k) % N]) j = (mptr + k) % N;
        end
        if (j >= 0) erdy[j] = 1'b1;
      end
      vectors++;
      if (bus.req_ready !== erdy) begin
        miscompares++; $display("FAIL rand_grant cyc=%0d got %b want %b", cyc, bus.req_ready, erdy);
      end
      if (expv && bus.rsp_ready) outst = 0;
      if (j >= 0) begin
        outst = 1; gcyc = cyc; eid = j; en = pn[j]; ed = pd[j];
        pend[j] = 1'b0; mptr = (j + 1) % N;
        if (ref_dbz(ed) && mcnt < 255) mcnt++;
      end
    end
    @(negedge clk);
    bus.req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_divbyzero();
    test_contention();
    test_backpressure();
    test_reset_calc();
    test_sweep();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rem_arbiter.md
# rem_arbiter

Round-robin arbiter and sequencer that shares a single combinational `rem` unit (3-bit sign-magnitude remainder with divide-by-zero flag) among several requesters. Each requester presents a numerator/denominator pair with a valid/ready handshake. The arbiter grants one request at a time, registers the operands into `rem`, and captures the result. It then returns the result with the requester's id over a valid/ready response port. The block also keeps a saturating count of divide-by-zero events for status readout.

## Interface
- `NUM_REQ`, default 4: number of requesters; a power of two, 2..8.
- `ID_W`, default $clog2(NUM_REQ): width of the response id.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input NUM_REQ: per-requester request valid.
- `req_num` input 3*NUM_REQ: numerators; slice i is [3*i+2:3*i]; bit 2 is sign, [1:0] is magnitude.
- `req_den` input 3*NUM_REQ: denominators; same slicing and format.
- `req_ready` output NUM_REQ: one-hot grant; combinational from `req_valid`, state and pointer.
- `rsp_valid` output 1: response valid.
- `rsp_id` output ID_W: index of the requester the response belongs to.
- `rsp_rem` output 3: remainder, sign-magnitude.
- `rsp_divbyzero` output 1: denominator magnitude was zero.
- `rsp_ready` input 1: consumer accepts the response.
- `busy` output 1: high whenever state ≠ IDLE.
- `dbz_count` output 8: saturating count of divide-by-zero results.

## Operation
- FSM has three states: IDLE, CALC, RESP. Reset state is IDLE.
- **IDLE**
  - If any `req_valid` is set, pick the first set bit searching upward from `ptr`, wrapping modulo NUM_REQ.
  - Drive `req_ready[g]`=1 for the chosen index g only.
  - Register `num_q`/`den_q` from slice g and `id_q`=g.
  - Set `ptr`=(g+1) mod NUM_REQ and go to CALC.
  - If no request is valid, stay in IDLE and leave `ptr` unchanged.
- **CALC**
  - `num_q`/`den_q` drive the `rem` instance.
  - On the clock edge, capture its outputs into the response registers and go to RESP.
- **RESP**
  - Hold `rsp_valid`=1 with `rsp_id`, `rsp_rem` and `rsp_divbyzero` stable.
  - If `rsp_ready`=1, go to IDLE.
  - No request is granted in RESP or CALC: `req_ready`=0.
- **Arithmetic**
  - Magnitude: `rsp_rem[1:0]` = `num[1:0]` % `den[1:0]`.
  - Sign: `rsp_rem[2]` = `num[2]`.
  - Divide-by-zero is flagged when `den[1:0]`==0, i.e. den 000 or 100. In that case the arbiter forces `rsp_rem` = {`num[2]`, 2'b00}, regardless of the `rem` magnitude output.
  - The denominator sign bit has no effect on the result.
- **Status counter**: `dbz_count` increments at CALC capture when divide-by-zero is flagged, and saturates at 255.

## Timing
- Reset values: state IDLE, `ptr`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_rem`=0, `rsp_divbyzero`=0, `busy`=0, `dbz_count`=0, `req_ready`=0.
- Latency: a grant in cycle T gives `rsp_valid`=1 from cycle T+2.
- Minimum spacing between grants is 3 cycles: grant, CALC, then RESP accepted immediately. The next grant comes in the cycle after the RESP handshake, never in the same cycle.
- Requester handshake: a transfer occurs when `req_valid[i]` && `req_ready[i]` in the same cycle. Requesters must hold `req_valid` and operands stable until granted. A request withdrawn before grant is simply not served.
- Consumer back-pressure: `rsp_ready`=0 in RESP stalls indefinitely. Outputs stay stable and no new grants are made.
- Wrap-around: with the grant at NUM_REQ-1, `ptr` becomes 0.
- Simultaneous requests: grants go strictly round-robin. No requester is served twice while another requester has been continuously valid.
- Reset mid-operation: an in-flight operation in CALC or RESP is discarded with no response, and all registers return to their reset values in the same edge.

## Structure
- Shared package `rem_pkg` holds:
  - the state enum (IDLE, CALC, RESP);
  - `REM_W`=3 and `SIGN_BIT`=2;
  - `DBZ_CNT_W`=8.
- Sub-module: one instance of the existing `rem` (ports `numerator`, `denominator`, `remainder`, `divbyzero`).
- The round-robin picker stays inline; it is not a separate module.

## Test plan
- Single request: requester 2 with num 011 and den 010 while the others are idle → `req_ready`=0100 in T, then `rsp_valid` at T+2 with id 2, rem 001, dbz 0, `ptr`=3.
- Divide-by-zero: num 111 with den 100, then num 010 with den 000 → rem 100 dbz 1, then rem 000 dbz 1; `dbz_count`=2. Preload the counter to 255 and trigger once more → it stays at 255.
- Contention: all four requesters valid continuously from reset → grant order 0,1,2,3,0 with `rsp_id` matching each, and each grant 3 cycles apart when `rsp_ready`=1.
- Back-pressure: hold `rsp_ready`=0 for 5 cycles in RESP while requester 1 is valid → outputs stable, `req_ready`=0 throughout; release → requester 1 is granted the cycle after the handshake.
- Reset in CALC: assert `rst` for one cycle while in CALC → next cycle state IDLE, `rsp_valid`=0, `ptr`=0, `dbz_count` unchanged from reset value 0, and no response is ever issued for the dropped operation.
- Exhaustive sweep: all 64 num/den pairs through requester 0 → each response matches the magnitude-mod and sign rules above.
